// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM port arbiter: FSM state encoding, grant-owner
// codes and the per-mode requester eligibility mask.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_PROG = 2'd1;
  localparam logic [1:0] GNT_CPU  = 2'd2;
  localparam logic [1:0] GNT_DBG  = 2'd3;

  // Bit positions of the requesters inside eligibility vectors
  localparam int REQ_PROG = 0;
  localparam int REQ_CPU  = 1;
  localparam int REQ_DBG  = 2;

  // Program mode admits {dbg, prog}; run mode admits {dbg, cpu}
  function automatic logic [2:0] elig_mask(input logic prog_mode);
    return prog_mode ? 3'b101 : 3'b110;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the RAM port: mode masking, prog > dbg fixed priority in
// program mode, cpu/dbg round-robin in run mode with its registered pointer.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_mode,
  input  logic       i_prog_req,
  input  logic       i_cpu_req,
  input  logic       i_dbg_req,
  input  logic       i_take,
  output logic [1:0] o_winner
);

  logic       r_rr_dbg;
  logic [2:0] w_req;
  logic [2:0] w_mask;
  logic [2:0] w_elig;

  assign w_req  = {i_dbg_req, i_cpu_req, i_prog_req};
  assign w_mask = elig_mask(i_mode);

  for (genvar gi = 0; gi < 3; gi++) begin : g_elig
    assign w_elig[gi] = w_req[gi] & w_mask[gi];
  end

  // cpu and dbg can only both be eligible in run mode, so the round-robin
  // branch never competes with the program-mode fixed priority.
  always_comb begin
    o_winner = GNT_NONE;
    if (w_elig[REQ_PROG]) begin
      o_winner = GNT_PROG;
    end else if (w_elig[REQ_CPU] && w_elig[REQ_DBG]) begin
      o_winner = r_rr_dbg ? GNT_DBG : GNT_CPU;
    end else if (w_elig[REQ_CPU]) begin
      o_winner = GNT_CPU;
    end else if (w_elig[REQ_DBG]) begin
      o_winner = GNT_DBG;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_dbg <= 1'b0;
    end else if (i_take && !i_mode && (o_winner != GNT_NONE)) begin
      r_rr_dbg <= (o_winner == GNT_CPU);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Req/ack transaction sequencer sharing one single-port RAM between programmer,
// core and debug monitor. Define MEM_PORT_ARB_WRPROTECT_EN for low-page write protection.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int            AW         = 8,
  parameter int            DW         = 8,
  parameter int            RD_LAT     = 1,
  parameter logic [AW-1:0] PROT_LIMIT = 8'h10
)
(
  input  logic          clock,
  input  logic          reset,
  input  logic          mode,
  input  logic          prog_req,
  input  logic          prog_wr,
  input  logic [AW-1:0] prog_adrs,
  input  logic [DW-1:0] prog_wdata,
  output logic          prog_ack,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_adrs,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_adrs,
  output logic          dbg_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_adrs,
  output logic [DW-1:0] mem_data,
  output logic          mem_wr_en,
  input  logic [DW-1:0] mem_q,
  output logic          busy,
  output logic [1:0]    grant_id
`ifdef MEM_PORT_ARB_WRPROTECT_EN
  ,
  output logic          wr_viol
`endif
);

`ifdef MEM_PORT_ARB_WRPROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

  arb_state_t    r_state;
  logic [1:0]    r_grant_id;
  logic [1:0]    r_cnt;
  logic          r_wr;
  logic          r_wr_en;
  logic          r_busy;
  logic          r_prog_ack;
  logic          r_cpu_ack;
  logic          r_dbg_ack;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_mem_adrs;
  logic [DW-1:0] r_mem_data;

  logic [1:0]    w_winner;
  logic          w_take;
  logic          w_sel_wr;
  logic [AW-1:0] w_sel_adrs;
  logic [DW-1:0] w_sel_wdata;
  logic          w_wr_block;
  logic          w_ack_next;

  assign w_take = (r_state == IDLE) && (w_winner != GNT_NONE);

  mem_arb_pick u_pick (
    .clock      (clock),
    .reset      (reset),
    .i_mode     (mode),
    .i_prog_req (prog_req),
    .i_cpu_req  (cpu_req),
    .i_dbg_req  (dbg_req),
    .i_take     (w_take),
    .o_winner   (w_winner)
  );

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_adrs  = dbg_adrs;
    w_sel_wdata = '0;
    case (w_winner)
      GNT_PROG: begin
        w_sel_wr    = prog_wr;
        w_sel_adrs  = prog_adrs;
        w_sel_wdata = prog_wdata;
      end
      GNT_CPU: begin
        w_sel_wr    = cpu_wr;
        w_sel_adrs  = cpu_adrs;
        w_sel_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  // cpu only ever wins in run mode, so the owner check implies the mode check
  assign w_wr_block = PROT_EN && (w_winner == GNT_CPU) && w_sel_wr &&
                      (w_sel_adrs < PROT_LIMIT);

  assign w_ack_next = ((r_state == ISSUE) && r_wr) ||
                      ((r_state == RWAIT) && (r_cnt == 2'd0));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant_id <= GNT_NONE;
      r_cnt      <= 2'd0;
      r_wr       <= 1'b0;
      r_wr_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_prog_ack <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_dbg_ack  <= 1'b0;
      r_rdata    <= '0;
      r_mem_adrs <= '0;
      r_mem_data <= '0;
    end else begin
      r_prog_ack <= w_ack_next && (r_grant_id == GNT_PROG);
      r_cpu_ack  <= w_ack_next && (r_grant_id == GNT_CPU);
      r_dbg_ack  <= w_ack_next && (r_grant_id == GNT_DBG);
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_state    <= ISSUE;
            r_grant_id <= w_winner;
            r_busy     <= 1'b1;
            r_wr       <= w_sel_wr;
            r_mem_adrs <= w_sel_adrs;
            r_mem_data <= w_sel_wdata;
            r_wr_en    <= w_sel_wr && !w_wr_block;
          end
        end
        ISSUE: begin
          r_wr_en <= 1'b0;
          if (r_wr) begin
            r_state <= ACK;
          end else begin
            r_state <= RWAIT;
            r_cnt   <= CNT_LOAD;
          end
        end
        RWAIT: begin
          if (r_cnt == 2'd0) begin
            r_rdata <= mem_q;
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ACK: begin
          r_state    <= IDLE;
          r_grant_id <= GNT_NONE;
          r_busy     <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_PORT_ARB_WRPROTECT_EN
  logic r_wr_viol;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_viol <= 1'b0;
    end else if (w_take && w_wr_block) begin
      r_wr_viol <= 1'b1;
    end
  end

  assign wr_viol = r_wr_viol;
`endif

  // Reset gates the strobe immediately so a write caught in ISSUE never lands
  assign mem_wr_en = r_wr_en & ~reset;
  assign prog_ack  = r_prog_ack;
  assign cpu_ack   = r_cpu_ack;
  assign dbg_ack   = r_dbg_ack;
  assign rdata     = r_rdata;
  assign mem_adrs  = r_mem_adrs;
  assign mem_data  = r_mem_data;
  assign busy      = r_busy;
  assign grant_id  = r_grant_id;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single-port 8-bit program/data RAM between three requesters:
  - the memory programmer (program mode),
  - the CDEC8 core (run mode),
  - a debug monitor read port (both modes).
- Replaces the raw mode-based address/data/clock muxing in front of the RAM with a req/ack transaction FSM.
- Sits between the requesters and the RAM; the RAM runs on this block's clock.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- RD_LAT, 1, RAM read latency in cycles from address presented to mem_q valid (1..3).
- PROT_LIMIT, 8'h10, first unprotected address (used only with the optional feature).

Ports:
- clock  in  1  single system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  1 = program mode, 0 = run mode.
- prog_req  in  1  programmer request, level.
- prog_wr  in  1  1 = write, 0 = read.
- prog_adrs  in  AW  programmer address.
- prog_wdata  in  DW  programmer write data.
- prog_ack  out  1  one-cycle completion pulse.
- cpu_req  in  1  core request, level.
- cpu_wr  in  1  core write enable.
- cpu_adrs  in  AW  core address.
- cpu_wdata  in  DW  core write data.
- cpu_ack  out  1  one-cycle completion pulse.
- dbg_req  in  1  debug read request, level (read-only port).
- dbg_adrs  in  AW  debug address.
- dbg_ack  out  1  one-cycle completion pulse.
- rdata  out  DW  read data; valid in the ack cycle, held until the next read completes.
- mem_adrs  out  AW  RAM address.
- mem_data  out  DW  RAM write data.
- mem_wr_en  out  1  RAM write strobe.
- mem_q  in  DW  RAM read data.
- busy  out  1  high whenever the FSM is not in IDLE.
- grant_id  out  2  current owner: 0 = none, 1 = prog, 2 = cpu, 3 = dbg.

Behaviour:
- Reset values:
  - all acks 0, mem_wr_en 0, busy 0, grant_id 0;
  - rdata, mem_adrs, mem_data 0;
  - FSM in IDLE; round-robin pointer set to cpu.
- FSM states: IDLE, ISSUE, RWAIT, ACK.
  - IDLE:
    - Sample eligible requests.
    - If any is eligible, latch the winner's wr/adrs/wdata into internal registers, set grant_id, and go to ISSUE.
  - ISSUE:
    - Drive mem_adrs and mem_data from the latched values.
    - mem_wr_en = 1 for exactly this one cycle if the transaction is a write.
    - Write -> ACK.
    - Read -> RWAIT, with the counter loaded to RD_LAT-1.
  - RWAIT:
    - Hold mem_adrs.
    - When the counter reaches 0, capture mem_q into rdata and go to ACK.
  - ACK:
    - Pulse the winner's ack for one cycle.
    - Next state IDLE; grant_id returns to 0 on entry to IDLE.
- Latency from req high in IDLE to ack:
  - write: 3 cycles (IDLE, ISSUE, ACK);
  - read: 3 + RD_LAT cycles.
- Eligibility:
  - mode = 1: prog and dbg eligible; cpu masked. Fixed priority: prog > dbg.
  - mode = 0: cpu and dbg eligible; prog masked. Round-robin between them: the pointer flips to the other requester after each grant.
  - A lone requester always wins.
- Handshake rules:
  - Requesters hold req, wr, adrs and wdata stable until their ack.
  - A req still high in the cycle after ack is treated as a new transaction.
  - Inputs are latched in IDLE, so changes after the grant are ignored.
- A mode change mid-transaction does not abort it. The new mask applies at the next IDLE sampling.
- Reset mid-transaction:
  - FSM returns to IDLE on that edge.
  - mem_wr_en is forced 0 and no ack is issued.
  - A write in ISSUE during the reset cycle is not performed.
- Address/data wrap: none; AW-bit addresses are passed through unchanged.
- Masked requesters are never acked; their req is simply held pending.

Optional Feature:
- Macro: MEM_PORT_ARB_WRPROTECT_EN.
- With the macro defined:
  - In run mode, a cpu write with address < PROT_LIMIT is suppressed: mem_wr_en stays 0 in ISSUE.
  - The write is still acked normally.
  - Extra output port wr_viol (1 bit, reset 0) is set sticky on such a write and cleared only by reset.
  - prog and dbg are unaffected.
- Without the macro: all writes are performed, and the wr_viol port does not exist.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the FSM state encoding (IDLE = 2'd0, ISSUE = 2'd1, RWAIT = 2'd2, ACK = 2'd3);
  - the grant_id constants GNT_NONE / GNT_PROG / GNT_CPU / GNT_DBG.
- One sub-module, mem_arb_pick: combinational eligibility masking, priority and round-robin selection, plus the registered round-robin pointer.
- FSM and datapath registers stay in the top module.

Test Plan:
- Reset, then mode = 1, prog write 8'h3C to adrs 8'h05 -> mem_wr_en high for exactly 1 cycle with mem_adrs = 05, mem_data = 3C; prog_ack 3 cycles after req; grant_id = 1 during the transaction.
- mode = 1, prog read of 8'h05 with RD_LAT = 1 -> prog_ack at cycle 4 with rdata = 3C; rdata holds 3C afterwards.
- mode = 0, cpu_req and dbg_req asserted continuously -> grants alternate cpu, dbg, cpu, dbg; no ack for a held prog_req.
- mode = 1, prog_req and dbg_req in the same cycle -> prog is served first, then dbg; cpu_req is ignored.
- Reset asserted during ISSUE of a cpu write -> no mem_wr_en, no cpu_ack, FSM in IDLE, all outputs at reset values.
- With MEM_PORT_ARB_WRPROTECT_EN: cpu write to adrs 8'h02 -> cpu_ack pulses, mem_wr_en stays 0, wr_viol = 1 and stays 1; cpu write to 8'h20 -> performed normally.
